// File: rtl/op_link_rst_seq.sv
// Optical-link reset request sequencer: merges startup, slow-control and loss-of-lock
// requests, pulses the reset FSM request lines and retries until the affected links re-lock.
//
// state       | meaning
// S_IDLE      | waiting for a pending request
// S_ASSERT    | request outputs held high for REQ_HOLD cycles
// S_LOCK_WAIT | masked settle window, then waiting for the required locks
// S_FAIL      | retries exhausted; only a new edge request restarts
module op_link_rst_seq #(
    parameter int unsigned REQ_HOLD  = 8,
    parameter logic [15:0] LOCK_MASK = 16'd4096,
    parameter logic [15:0] LOCK_TMO  = 16'd40000,
    parameter logic [3:0]  MAX_RETRY = 4'd3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STARTUP,
    input  logic       DAQ_REQ,
    input  logic       TRG_REQ,
    input  logic       AUTO_EN,
    input  logic       DAQ_LOCK,
    input  logic       TRG_LOCK,
    output logic       STRTUP_OP_RST,
    output logic       DAQ_OP_RST,
    output logic       TRG_OP_RST,
    output logic       BUSY,
    output logic       FAIL,
    output logic [7:0] RST_CNT
);

    localparam logic [15:0] HOLD_LAST = 16'(REQ_HOLD - 1);
    localparam logic [15:0] TMO_LAST  = LOCK_TMO - 16'd1;

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_LOCK_WAIT, S_FAIL} state_t;

    state_t      state;
    logic        strt_q, daq_q, trg_q;
    logic [2:0]  pend;      // {strt_p, daq_p, trg_p}
    logic [2:0]  iss;       // {is_s, is_d, is_t}
    logic        armed;
    logic [15:0] timer;
    logic [3:0]  retry;

    logic [2:0]  edge_bits;
    logic [2:0]  auto_bits;
    logic        auto_fire;
    logic        need_daq, need_trg, locked;

    assign edge_bits = {STARTUP & ~strt_q, DAQ_REQ & ~daq_q, TRG_REQ & ~trg_q};
    assign auto_fire = AUTO_EN && armed && (state == S_IDLE) && !(DAQ_LOCK && TRG_LOCK);
    assign auto_bits = auto_fire ? {1'b0, ~DAQ_LOCK, ~TRG_LOCK} : 3'b000;
    // A startup reset touches both links, so both must re-lock.
    assign need_daq  = iss[2] | iss[1];
    assign need_trg  = iss[2] | iss[0];
    assign locked    = (!need_daq || DAQ_LOCK) && (!need_trg || TRG_LOCK);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            strt_q        <= 1'b0;
            daq_q         <= 1'b0;
            trg_q         <= 1'b0;
            pend          <= 3'b000;
            iss           <= 3'b000;
            armed         <= 1'b0;
            timer         <= 16'd0;
            retry         <= 4'd0;
            STRTUP_OP_RST <= 1'b0;
            DAQ_OP_RST    <= 1'b0;
            TRG_OP_RST    <= 1'b0;
            BUSY          <= 1'b0;
            FAIL          <= 1'b0;
            RST_CNT       <= 8'd0;
        end else begin
            strt_q <= STARTUP;
            daq_q  <= DAQ_REQ;
            trg_q  <= TRG_REQ;
            pend   <= pend | edge_bits | auto_bits;
            if (auto_fire) armed <= 1'b0;

            case (state)
                S_IDLE, S_FAIL: begin
                    if (|pend) begin
                        // Requests arriving this very cycle stay pending for the next attempt.
                        pend  <= edge_bits | auto_bits;
                        iss   <= pend;
                        retry <= 4'd0;
                        timer <= 16'd0;
                        if (RST_CNT != 8'hFF) RST_CNT <= RST_CNT + 8'd1;
                        {STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST} <= pend;
                        BUSY  <= 1'b1;
                        FAIL  <= 1'b0;
                        state <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (timer == HOLD_LAST) begin
                        timer <= 16'd0;
                        {STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST} <= 3'b000;
                        state <= S_LOCK_WAIT;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_LOCK_WAIT: begin
                    if (timer >= LOCK_MASK && locked) begin
                        armed <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else if (timer == TMO_LAST) begin
                        timer <= 16'd0;
                        if (retry < MAX_RETRY) begin
                            retry <= retry + 4'd1;
                            if (RST_CNT != 8'hFF) RST_CNT <= RST_CNT + 8'd1;
                            {STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST} <= iss;
                            state <= S_ASSERT;
                        end else begin
                            armed <= 1'b0;
                            BUSY  <= 1'b0;
                            FAIL  <= 1'b1;
                            state <= S_FAIL;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_link_rst_seq.sv
// Directed scenarios with randomized timing for op_link_rst_seq; expected pulse times are
// derived from the timing rules by arithmetic and compared against a per-cycle output log.
module tb_op_link_rst_seq;

    localparam int HOLD = 8;
    localparam int MASK = 16;
    localparam int TMO  = 64;
    localparam int MAXR = 2;
    localparam int NC   = 4096;
    localparam int NEVER = 1 << 30;

    // hist bit positions
    localparam int B_BUSY = 4;
    localparam int B_FAIL = 3;
    localparam int B_S    = 2;
    localparam int B_D    = 1;
    localparam int B_T    = 0;

    logic       CLK = 1'b0;
    logic       RST, STARTUP, DAQ_REQ, TRG_REQ, AUTO_EN, DAQ_LOCK, TRG_LOCK;
    logic       STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST, BUSY, FAIL;
    logic [7:0] RST_CNT;

    op_link_rst_seq #(
        .REQ_HOLD (HOLD),
        .LOCK_MASK(16'd16),
        .LOCK_TMO (16'd64),
        .MAX_RETRY(4'd2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .STARTUP      (STARTUP),
        .DAQ_REQ      (DAQ_REQ),
        .TRG_REQ      (TRG_REQ),
        .AUTO_EN      (AUTO_EN),
        .DAQ_LOCK     (DAQ_LOCK),
        .TRG_LOCK     (TRG_LOCK),
        .STRTUP_OP_RST(STRTUP_OP_RST),
        .DAQ_OP_RST   (DAQ_OP_RST),
        .TRG_OP_RST   (TRG_OP_RST),
        .BUSY         (BUSY),
        .FAIL         (FAIL),
        .RST_CNT      (RST_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    logic [4:0] hist [NC];
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (cyc < NC) hist[cyc] = {BUSY, FAIL, STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST};

    // Reference model output: attempt start cycles, cycle BUSY first reads low, fail flag.
    int exp_st[$];
    int exp_end;
    int exp_fail;
    int st[$];
    int wd[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the point 1 time unit after the posedge that makes cyc == c.
    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Request driven at cycle d gives a first start at d+2; lock (all required) reads
    // high at every sampled cycle >= lk. Each attempt: HOLD high, then success at
    // max(MASK, lk-fall) if below TMO, else the next attempt starts TMO after the fall.
    function automatic void predict(input int first, input int lk);
        int s;
        int f;
        int t;
        s = first;
        exp_st.delete();
        exp_fail = 0;
        for (int a = 0; a <= MAXR; a++) begin
            exp_st.push_back(s);
            f = s + HOLD;
            t = (lk - f > MASK) ? lk - f : MASK;
            if (t < TMO) begin
                exp_end = f + t + 1;
                return;
            end
            s = f + TMO;
        end
        exp_fail = 1;
        exp_end  = s;
    endfunction

    task automatic scan(input int lo, input int hi, input int b);
        st.delete();
        wd.delete();
        for (int c = lo; c <= hi; c++) begin
            if (hist[c][b] && !hist[c-1][b]) begin
                st.push_back(c);
                wd.push_back(0);
            end
            if (hist[c][b] && wd.size() > 0) wd[wd.size()-1]++;
        end
    endtask

    function automatic int first_low(input int lo, input int hi, input int b);
        for (int c = lo; c <= hi; c++)
            if (!hist[c][b]) return c;
        return -1;
    endfunction

    task automatic check_attempts(input string tag, input int b, input int lo, input int hi);
        scan(lo, hi, b);
        chk({tag, "_count"}, st.size(), exp_st.size());
        foreach (exp_st[i]) begin
            chk({tag, "_start"}, (i < st.size()) ? st[i] : -1, exp_st[i]);
            chk({tag, "_width"}, (i < wd.size()) ? wd[i] : -1, HOLD);
        end
    endtask

    task automatic check_none(input string tag, input int b, input int lo, input int hi);
        scan(lo, hi, b);
        chk(tag, st.size(), 0);
    endtask

    initial begin
        int d, lk, e, tt, x, g, y, r, rel;

        RST = 1'b1;
        STARTUP = 1'b0; DAQ_REQ = 1'b0; TRG_REQ = 1'b0; AUTO_EN = 1'b0;
        DAQ_LOCK = 1'b0; TRG_LOCK = 1'b0;
        go_to(3);
        chk("reset_outputs", int'({STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST, BUSY, FAIL}), 0);
        chk("reset_cnt", int'(RST_CNT), 0);
        RST = 1'b0;

        // Startup request, both locks rise at a random time (may force retries).
        d  = cyc + int'($urandom_range(2, 6));
        lk = d + int'($urandom_range(5, 150));
        go_to(d);
        STARTUP = 1'b1;
        go_to(lk);
        DAQ_LOCK = 1'b1;
        TRG_LOCK = 1'b1;
        predict(d + 2, lk);
        go_to(exp_end + 5);
        check_attempts("strt", B_S, d, exp_end + 4);
        check_none("strt_no_daq", B_D, d, exp_end + 4);
        chk("strt_busy_end", first_low(d + 2, exp_end + 4, B_BUSY), exp_end);
        chk("strt_fail_flag", int'(hist[exp_end][B_FAIL]), exp_fail);
        exp_cnt += exp_st.size();
        chk("strt_cnt", int'(RST_CNT), exp_cnt);

        // DAQ and TRG requests in the same cycle merge into one attempt.
        d = cyc + int'($urandom_range(3, 9));
        go_to(d);
        DAQ_REQ = 1'b1;
        TRG_REQ = 1'b1;
        predict(d + 2, 0);
        go_to(exp_end + 5);
        check_attempts("merge_daq", B_D, d, exp_end + 4);
        check_attempts("merge_trg", B_T, d, exp_end + 4);
        check_none("merge_no_strt", B_S, d, exp_end + 4);
        chk("merge_busy_end", first_low(d + 2, exp_end + 4, B_BUSY), exp_end);
        exp_cnt += 1;
        chk("merge_cnt", int'(RST_CNT), exp_cnt);
        DAQ_REQ = 1'b0;
        TRG_REQ = 1'b0;

        // DAQ request with DAQ lock held low: all retries time out, then Fail.
        DAQ_LOCK = 1'b0;
        d = cyc + int'($urandom_range(3, 9));
        go_to(d);
        DAQ_REQ = 1'b1;
        predict(d + 2, NEVER);
        go_to(exp_end + 3);
        check_attempts("tmo", B_D, d, exp_end + 2);
        chk("tmo_fail_flag", int'(hist[exp_end][B_FAIL]), 1);
        chk("tmo_busy_end", first_low(d + 2, exp_end + 2, B_BUSY), exp_end);
        chk("tmo_fail_port", int'(FAIL), 1);
        exp_cnt += MAXR + 1;
        chk("tmo_cnt", int'(RST_CNT), exp_cnt);
        DAQ_REQ = 1'b0;

        // A new DAQ edge leaves Fail and starts a fresh attempt.
        d  = cyc + int'($urandom_range(3, 10));
        lk = d + int'($urandom_range(5, 100));
        go_to(d);
        DAQ_REQ = 1'b1;
        go_to(lk);
        DAQ_LOCK = 1'b1;
        predict(d + 2, lk);
        go_to(exp_end + 5);
        chk("refail_held", int'(hist[d + 1][B_FAIL]), 1);
        chk("refail_cleared", int'(hist[d + 2][B_FAIL]), 0);
        check_attempts("refail", B_D, d, exp_end + 4);
        chk("refail_busy_end", first_low(d + 2, exp_end + 4, B_BUSY), exp_end);
        exp_cnt += exp_st.size();
        chk("refail_cnt", int'(RST_CNT), exp_cnt);
        DAQ_REQ = 1'b0;

        // TRG edge during DAQ lock wait is served right after Idle.
        d = cyc + int'($urandom_range(3, 9));
        go_to(d);
        DAQ_REQ = 1'b1;
        predict(d + 2, 0);
        e  = exp_end;
        tt = d + 10 + int'($urandom_range(1, 12));
        go_to(tt);
        TRG_REQ = 1'b1;
        go_to(e + 2);
        check_attempts("queued_daq", B_D, d, e + 1);
        chk("queued_idle_gap", int'(hist[e][B_BUSY]), 0);
        predict(e + 1, 0);
        go_to(exp_end + 5);
        check_attempts("queued_trg", B_T, d, exp_end + 4);
        chk("queued_busy_end", first_low(e + 1, exp_end + 4, B_BUSY), exp_end);
        exp_cnt += 2;
        chk("queued_cnt", int'(RST_CNT), exp_cnt);
        DAQ_REQ = 1'b0;
        TRG_REQ = 1'b0;

        // Auto request: one-cycle DAQ lock drop fires exactly once until re-armed.
        AUTO_EN = 1'b1;
        x = cyc + int'($urandom_range(3, 8));
        go_to(x);
        DAQ_LOCK = 1'b0;
        go_to(x + 1);
        DAQ_LOCK = 1'b1;
        predict(x + 2, 0);
        g = x + 10 + int'($urandom_range(1, 10));
        go_to(g);
        DAQ_LOCK = 1'b0;
        go_to(g + 1);
        DAQ_LOCK = 1'b1;
        go_to(exp_end + 30);
        check_attempts("auto_daq", B_D, x, exp_end + 29);
        chk("auto_busy_end", first_low(x + 2, exp_end + 29, B_BUSY), exp_end);
        exp_cnt += 1;
        chk("auto_cnt", int'(RST_CNT), exp_cnt);

        // Re-armed by that success: a TRG lock drop now fires one TRG attempt.
        y = cyc + int'($urandom_range(3, 8));
        go_to(y);
        TRG_LOCK = 1'b0;
        go_to(y + 1);
        TRG_LOCK = 1'b1;
        predict(y + 2, 0);
        go_to(exp_end + 20);
        check_attempts("rearm_trg", B_T, y, exp_end + 19);
        check_none("rearm_no_daq", B_D, y, exp_end + 19);
        exp_cnt += 1;
        chk("rearm_cnt", int'(RST_CNT), exp_cnt);
        AUTO_EN = 1'b0;

        // Reset mid-Assert drops outputs at once and discards the request.
        d = cyc + int'($urandom_range(3, 9));
        r = int'($urandom_range(0, 7));
        go_to(d);
        DAQ_REQ = 1'b1;
        go_to(d + 2 + r);
        chk("midrst_pre_high", int'(DAQ_OP_RST), 1);
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_out_low", int'({STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST, BUSY}), 0);
        chk("midrst_cnt", int'(RST_CNT), 0);
        DAQ_REQ = 1'b0;
        STARTUP = 1'b0;
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b0;
        rel = cyc;
        go_to(rel + 100);
        check_none("midrst_no_daq", B_D, rel + 1, rel + 99);
        check_none("midrst_no_strt", B_S, rel + 1, rel + 99);
        chk("midrst_idle", int'(hist[rel + 99][B_BUSY]), 0);
        chk("midrst_cnt_after", int'(RST_CNT), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/op_link_rst_seq.md
# op_link_rst_seq

Sequencer that drives the request inputs of the optical-link reset FSM (STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST).
- Merges startup, slow-control and automatic loss-of-lock reset requests.
- Issues timed request pulses, then checks that the affected links re-lock.
- Retries a bounded number of times and flags a permanent failure.
- Sits between the startup/slow-control logic and the link reset FSM; its lock inputs come from the DAQ and TRG transceiver status.

## Interface
Parameters:
- REQ_HOLD, 8: cycles each request output is held high per attempt (1..255).
- LOCK_MASK, 16'd4096: cycles after request release during which lock inputs are ignored. Must exceed the reset FSM pulse duration.
- LOCK_TMO, 16'd40000: cycles after request release by which lock is required. Must be > LOCK_MASK.
- MAX_RETRY, 4'd3: re-attempts after the first timeout before failing.

Ports:
- CLK  in  1  system clock; sole clock.
- RST  in  1  asynchronous, active-high reset.
- STARTUP  in  1  power-up complete. Rising edge requests a startup reset of both links.
- DAQ_REQ  in  1  slow-control DAQ link reset. Rising edge is a request.
- TRG_REQ  in  1  slow-control TRG link reset. Rising edge is a request.
- AUTO_EN  in  1  enables automatic reset on loss of lock.
- DAQ_LOCK  in  1  DAQ link locked (synchronous to CLK).
- TRG_LOCK  in  1  TRG link locked (synchronous to CLK).
- STRTUP_OP_RST  out  1  registered request to reset FSM, startup type.
- DAQ_OP_RST  out  1  registered request, DAQ link.
- TRG_OP_RST  out  1  registered request, TRG link.
- BUSY  out  1  high in any state except Idle and Fail.
- FAIL  out  1  high in Fail.
- RST_CNT  out  8  count of Assert entries; saturates at 255.

## Operation
Edge detect and pending latches:
- Each of STARTUP, DAQ_REQ and TRG_REQ has a registered previous value.
- A rising edge sets the matching pending bit: strt_p, daq_p or trg_p. This happens in every state, including while busy.
- Auto requests: AUTO_EN=1, state Idle and armed=1.
  - DAQ_LOCK=0 sets daq_p.
  - TRG_LOCK=0 sets trg_p.
  - armed then clears.
- armed sets on successful Lock_Wait exit. It clears on Fail, on RST, or when an auto request fires.

States: Idle, Assert, Lock_Wait, Fail.
- Idle: if any pending bit is set, go to Assert.
  - Copy pending into issued bits (is_s, is_d, is_t) and clear pending.
  - Clear the retry counter.
  - Increment RST_CNT.
- Assert:
  - Outputs: STRTUP_OP_RST=is_s, DAQ_OP_RST=is_d, TRG_OP_RST=is_t.
  - Timer counts 0..REQ_HOLD-1.
  - At REQ_HOLD-1: go to Lock_Wait, clear the timer, and drop all request outputs.
- Lock_Wait:
  - Timer increments every cycle.
  - Required lock: DAQ_LOCK if is_d or is_s; TRG_LOCK if is_t or is_s.
  - Success: timer >= LOCK_MASK and all required locks high. Set armed and go to Idle. Pending requests latched meanwhile are served from Idle on the next cycle.
  - Timeout: timer == LOCK_TMO-1 without success.
    - If retry < MAX_RETRY: increment retry and RST_CNT, go to Assert with the same issued bits.
    - Otherwise go to Fail.
- Fail:
  - FAIL=1; outputs low.
  - Any new pending bit (edge-generated only; auto requests are disabled) clears FAIL and goes to Assert via the Idle rules.

Other rules:
- Simultaneous requests in the same cycle merge into a single attempt.
- Timer width is 16 bits.
- The retry counter is 4 bits.

## Timing
- Reset values: all outputs 0, RST_CNT=0, pending/issued/armed=0, state Idle.
- Asserting RST mid-operation forces request outputs low asynchronously. Requests in flight are discarded.
- Request latency: rising edge sampled at edge k sets pending at edge k. Assert is entered and outputs go high after edge k+1.
- Request outputs are high for exactly REQ_HOLD cycles per attempt.
- Lock is first sampled LOCK_MASK cycles after the outputs fall. A lock already high at that point gives success in that cycle, and Idle follows at the next edge.
- A timeout re-asserts the request outputs on the cycle after timer == LOCK_TMO-1.
- BUSY rises with the Assert entry and falls on the Idle/Fail entry.

## Test plan
- Use REQ_HOLD=8, LOCK_MASK=16, LOCK_TMO=64, MAX_RETRY=2 for all scenarios.
- Reset release, STARTUP 0->1, both locks high from cycle 20 -> STRTUP_OP_RST high for 8 cycles starting 2 cycles after the edge; BUSY clears 17 cycles after the fall; RST_CNT=1.
- DAQ_REQ and TRG_REQ rise in the same cycle -> one 8-cycle attempt with DAQ_OP_RST=TRG_OP_RST=1 and STRTUP_OP_RST=0; RST_CNT=1.
- DAQ_REQ with DAQ_LOCK held low -> 3 attempts, each 8 cycles high and 64 cycles apart in Lock_Wait; then FAIL=1, BUSY=0, RST_CNT=3. A later DAQ_REQ edge clears FAIL and starts a new attempt.
- TRG_REQ edge during a DAQ attempt's Lock_Wait -> DAQ attempt completes, then TRG_OP_RST asserts 1 cycle after Idle is entered.
- AUTO_EN=1 after a successful DAQ reset, DAQ_LOCK drops for 1 cycle -> exactly one automatic DAQ attempt; no second one until a success re-arms.
- RST pulsed during Assert -> outputs low immediately; RST_CNT=0; no attempt resumes after release.
